// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Round-robin arbiter that grants up to two functional-unit (FU) results
//   per cycle onto two common data buses (CDB1, CDB2). The scan starts at a
//   round-robin pointer. The first valid FU found takes slot 1 (CDB1) and the
//   second takes slot 2 (CDB2). Granted results are broadcast on the next
//   rising clock edge.
//
// Handshake (valid/ready):
//   An FU raises fu_valid_in[i] and holds its tag, value and mispredict flag
//   stable until it sees fu_ready_out[i] high in the same cycle. That cycle
//   is the transfer. fu_ready_out is a pure function of fu_valid_in, the
//   round-robin pointer, flush and reset. Nothing downstream can
//   back-pressure a grant.
//
// Ports:
//   clock                  rising-edge clock
//   reset                  synchronous, active-high reset
//   flush                  mispredict recovery; drops every grant this cycle
//   fu_valid_in[N]         per-FU result request
//   fu_tag_in[8N]          per-FU ROB tag, FU i in bits [8i+7:8i]
//   fu_value_in[DW*N]      per-FU result value, FU i in slice i
//   fu_mispredicted_in[N]  per-FU branch-mispredict flag
//   fu_ready_out[N]        per-FU grant (combinational)
//   cdb{1,2}_tag_out       broadcast tags (registered)
//   cdb{1,2}_value_out     broadcast values (registered)
//   cdb{1,2}_mispredicted_out  broadcast mispredict flags (registered)
//   rr_ptr_out             current round-robin pointer (debug)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int          NUM_FU     = 4,
  parameter int          DATA_WIDTH = 32,
  parameter logic [7:0]  RSTAG_NULL = 8'hFF,
  localparam int         PTR_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_FU-1:0]            fu_valid_in,
  input  logic [8*NUM_FU-1:0]          fu_tag_in,
  input  logic [DATA_WIDTH*NUM_FU-1:0] fu_value_in,
  input  logic [NUM_FU-1:0]            fu_mispredicted_in,
  output logic [NUM_FU-1:0]            fu_ready_out,
  output logic [7:0]                   cdb1_tag_out,
  output logic [DATA_WIDTH-1:0]        cdb1_value_out,
  output logic                         cdb1_mispredicted_out,
  output logic [7:0]                   cdb2_tag_out,
  output logic [DATA_WIDTH-1:0]        cdb2_value_out,
  output logic                         cdb2_mispredicted_out,
  output logic [PTR_W-1:0]             rr_ptr_out
);

  localparam logic [PTR_W:0]   NUM_FU_W = (PTR_W+1)'(NUM_FU);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_FU - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [7:0]            cdb1_tag_q, cdb1_tag_d;
  logic [DATA_WIDTH-1:0] cdb1_value_q, cdb1_value_d;
  logic                  cdb1_misp_q, cdb1_misp_d;
  logic [7:0]            cdb2_tag_q, cdb2_tag_d;
  logic [DATA_WIDTH-1:0] cdb2_value_q, cdb2_value_d;
  logic                  cdb2_misp_q, cdb2_misp_d;

  // -------------------------------------------------------------------------
  // Circular scan from rr_ptr_q. Each slot index is kept separately from its
  // found flag so the data muxes below need no priority encoding.
  // -------------------------------------------------------------------------
  logic                  slot1_found, slot2_found;
  logic [PTR_W-1:0]      slot1_idx, slot2_idx;
  logic [NUM_FU-1:0]     slot_sel;

  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    slot1_found = 1'b0;
    slot2_found = 1'b0;
    slot1_idx   = '0;
    slot2_idx   = '0;
    slot_sel    = '0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      // (rr_ptr + k) mod NUM_FU without a divider. The sum is below 2*NUM_FU.
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum >= NUM_FU_W) begin
        sum = sum - NUM_FU_W;
      end
      idx = sum[PTR_W-1:0];
      if (fu_valid_in[idx]) begin
        if (!slot1_found) begin
          slot1_found   = 1'b1;
          slot1_idx     = idx;
          slot_sel[idx] = 1'b1;
        end else if (!slot2_found) begin
          // Each index is visited once per scan. Slot 2 can never repeat
          // the slot-1 requester.
          slot2_found   = 1'b1;
          slot2_idx     = idx;
          slot_sel[idx] = 1'b1;
        end
      end
    end
  end

  // Grants are suppressed by reset or flush. Reset takes priority over flush,
  // and both have the same effect on the grant vector.
  logic grant_block;
  assign grant_block  = reset | flush;
  assign fu_ready_out = grant_block ? '0 : slot_sel;

  // -------------------------------------------------------------------------
  // Round-robin pointer update
  // -------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
    next_idx = (i == LAST_IDX) ? '0 : i + PTR_W'(1);
  endfunction

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_block) begin
      rr_ptr_d = '0;
    end else if (slot2_found) begin
      rr_ptr_d = next_idx(slot2_idx);
    end else if (slot1_found) begin
      rr_ptr_d = next_idx(slot1_idx);
    end
  end

  // -------------------------------------------------------------------------
  // Broadcast data for the next cycle. An unfilled slot is null. A granted FU
  // that carries the null tag is consumed, but its slot broadcasts null.
  // -------------------------------------------------------------------------
  logic [7:0]            slot1_tag, slot2_tag;
  logic [DATA_WIDTH-1:0] slot1_value, slot2_value;
  logic                  slot1_misp, slot2_misp;

  assign slot1_tag   = fu_tag_in[int'(slot1_idx)*8 +: 8];
  assign slot2_tag   = fu_tag_in[int'(slot2_idx)*8 +: 8];
  assign slot1_value = fu_value_in[int'(slot1_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign slot2_value = fu_value_in[int'(slot2_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign slot1_misp  = fu_mispredicted_in[slot1_idx];
  assign slot2_misp  = fu_mispredicted_in[slot2_idx];

  always_comb begin
    cdb1_tag_d   = RSTAG_NULL;
    cdb1_value_d = '0;
    cdb1_misp_d  = 1'b0;
    cdb2_tag_d   = RSTAG_NULL;
    cdb2_value_d = '0;
    cdb2_misp_d  = 1'b0;
    if (!grant_block) begin
      if (slot1_found && (slot1_tag != RSTAG_NULL)) begin
        cdb1_tag_d   = slot1_tag;
        cdb1_value_d = slot1_value;
        cdb1_misp_d  = slot1_misp;
      end
      if (slot2_found && (slot2_tag != RSTAG_NULL)) begin
        cdb2_tag_d   = slot2_tag;
        cdb2_value_d = slot2_value;
        cdb2_misp_d  = slot2_misp;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers. Reset is synchronous and is folded into the _d logic above.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    rr_ptr_q     <= rr_ptr_d;
    cdb1_tag_q   <= cdb1_tag_d;
    cdb1_value_q <= cdb1_value_d;
    cdb1_misp_q  <= cdb1_misp_d;
    cdb2_tag_q   <= cdb2_tag_d;
    cdb2_value_q <= cdb2_value_d;
    cdb2_misp_q  <= cdb2_misp_d;
  end

  // A broadcast registered just before reset rises would otherwise be
  // visible for the first reset cycle. Holding the buses null while reset is
  // high ensures that no pre-reset grant ever reaches a consumer.
  assign cdb1_tag_out          = reset ? RSTAG_NULL : cdb1_tag_q;
  assign cdb1_value_out        = reset ? '0         : cdb1_value_q;
  assign cdb1_mispredicted_out = reset ? 1'b0       : cdb1_misp_q;
  assign cdb2_tag_out          = reset ? RSTAG_NULL : cdb2_tag_q;
  assign cdb2_value_out        = reset ? '0         : cdb2_value_q;
  assign cdb2_mispredicted_out = reset ? 1'b0       : cdb2_misp_q;

  assign rr_ptr_out = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter with NUM_FU=4 and DATA_WIDTH=32.
// A reference model tracks the round-robin pointer as an integer. Each cycle
// it lists the valid FUs in circular order from that pointer and takes the
// first two. The grant vector is compared in the same cycle. The predicted
// CDB contents go into an expected queue and are compared after the edge.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int         N   = 4;
  localparam int         DW  = 32;
  localparam logic [7:0] NUL = 8'hFF;
  localparam int         SW  = 8 + DW + 1;
  localparam int         EW  = 2 * SW;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  logic flush;
  always #5 clock = ~clock;

  logic [N-1:0]    fu_valid_in;
  logic [8*N-1:0]  fu_tag_in;
  logic [DW*N-1:0] fu_value_in;
  logic [N-1:0]    fu_mispredicted_in;
  logic [N-1:0]    fu_ready_out;
  logic [7:0]      cdb1_tag_out, cdb2_tag_out;
  logic [DW-1:0]   cdb1_value_out, cdb2_value_out;
  logic            cdb1_mispredicted_out, cdb2_mispredicted_out;
  logic [1:0]      rr_ptr_out;

  cdb_arbiter #(.NUM_FU(N), .DATA_WIDTH(DW), .RSTAG_NULL(NUL)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .flush                 (flush),
    .fu_valid_in           (fu_valid_in),
    .fu_tag_in             (fu_tag_in),
    .fu_value_in           (fu_value_in),
    .fu_mispredicted_in    (fu_mispredicted_in),
    .fu_ready_out          (fu_ready_out),
    .cdb1_tag_out          (cdb1_tag_out),
    .cdb1_value_out        (cdb1_value_out),
    .cdb1_mispredicted_out (cdb1_mispredicted_out),
    .cdb2_tag_out          (cdb2_tag_out),
    .cdb2_value_out        (cdb2_value_out),
    .cdb2_mispredicted_out (cdb2_mispredicted_out),
    .rr_ptr_out            (rr_ptr_out)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  logic [EW-1:0] exp_q[$];
  logic [N-1:0]  last_grant;

  // per-FU request contents presented by the bench
  logic [N-1:0]  tb_valid;
  logic [N-1:0]  tb_misp;
  logic [7:0]    tb_tag[N];
  logic [DW-1:0] tb_val[N];

  function automatic logic [EW-1:0] cdb_now();
    cdb_now = {cdb1_tag_out, cdb1_value_out, cdb1_mispredicted_out,
               cdb2_tag_out, cdb2_value_out, cdb2_mispredicted_out};
  endfunction

  function automatic logic [EW-1:0] null_pair();
    logic [SW-1:0] n;
    n = {NUL, {DW{1'b0}}, 1'b0};
    null_pair = {n, n};
  endfunction

  // driver tasks
  task automatic clear_fus();
    tb_valid = '0;
    tb_misp  = '0;
    for (int i = 0; i < N; i++) begin
      tb_tag[i] = 8'h00;
      tb_val[i] = '0;
    end
  endtask

  task automatic set_fu(input int i, input logic [7:0] t, input logic [DW-1:0] v,
                        input logic m);
    tb_valid[i] = 1'b1;
    tb_tag[i]   = t;
    tb_val[i]   = v;
    tb_misp[i]  = m;
  endtask

  task automatic apply_inputs(input logic rst, input logic fl);
    reset              = rst;
    flush              = fl;
    fu_valid_in        = tb_valid;
    fu_mispredicted_in = tb_misp;
    for (int i = 0; i < N; i++) begin
      fu_tag_in[8*i +: 8]    = tb_tag[i];
      fu_value_in[DW*i +: DW] = tb_val[i];
    end
  endtask

  // One full cycle: drive, model, check grants, check the broadcast after the edge.
  task automatic drive_cycle(input logic rst, input logic fl);
    logic [N-1:0]  exp_ready;
    logic [SW-1:0] e1, e2;
    logic [EW-1:0] want, got;
    int sel[2];
    int found;
    int i;
    apply_inputs(rst, fl);
    #1;
    exp_ready = '0;
    found     = 0;
    sel[0]    = 0;
    sel[1]    = 0;
    e1        = {NUL, {DW{1'b0}}, 1'b0};
    e2        = e1;
    if (!rst && !fl) begin
      for (int k = 0; k < N; k++) begin
        i = (model_ptr + k) % N;
        if (tb_valid[i] && found < 2) begin
          sel[found]   = i;
          exp_ready[i] = 1'b1;
          found++;
        end
      end
      if (found >= 1 && tb_tag[sel[0]] != NUL) e1 = {tb_tag[sel[0]], tb_val[sel[0]], tb_misp[sel[0]]};
      if (found == 2 && tb_tag[sel[1]] != NUL) e2 = {tb_tag[sel[1]], tb_val[sel[1]], tb_misp[sel[1]]};
      if (found > 0) model_ptr = (sel[found-1] + 1) % N;
    end else begin
      model_ptr = 0;
    end
    checks++;
    if (fu_ready_out !== exp_ready) begin
      errors++;
      $display("FAIL ready t=%0t got=%b exp=%b", $time, fu_ready_out, exp_ready);
    end
    if (rst) begin
      checks++;
      if (cdb_now() !== null_pair()) begin
        errors++;
        $display("FAIL cdb_in_reset t=%0t got=%h exp=%h", $time, cdb_now(), null_pair());
      end
    end
    last_grant = exp_ready;
    exp_q.push_back({e1, e2});
    @(posedge clock);
    #1;
    want = exp_q.pop_front();
    got  = cdb_now();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL cdb t=%0t got=%h exp=%h", $time, got, want);
    end
    checks++;
    if (int'(rr_ptr_out) != model_ptr) begin
      errors++;
      $display("FAIL rr_ptr t=%0t got=%0d exp=%0d", $time, rr_ptr_out, model_ptr);
    end
  endtask

  task automatic do_reset();
    clear_fus();
    drive_cycle(1'b1, 1'b0);
    clear_fus();
  endtask

  // tests
  task automatic test_reset();
    clear_fus();
    tb_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      tb_tag[i] = 8'(i + 1);
      tb_val[i] = $urandom;
    end
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    clear_fus();
    for (int c = 0; c < 3; c++) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic test_single();
    do_reset();
    set_fu(1, 8'h05, 32'hDEAD_BEEF, 1'b1);
    drive_cycle(1'b0, 1'b0);
    checks++;
    if (last_grant !== 4'b0010 || model_ptr != 2) begin
      errors++;
      $display("FAIL single_model grant=%b ptr=%0d exp=0010/2", last_grant, model_ptr);
    end
    clear_fus();
    drive_cycle(1'b0, 1'b0);
  endtask

  task automatic test_all_valid();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) set_fu(i, 8'(16*c + i), $urandom, 1'($urandom_range(0, 1)));
      drive_cycle(1'b0, 1'b0);
      checks++;
      if (last_grant !== ((c % 2 == 0) ? 4'b0011 : 4'b1100)) begin
        errors++;
        $display("FAIL all_valid_pair cycle=%0d grant=%b", c, last_grant);
      end
    end
    clear_fus();
    drive_cycle(1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    set_fu(2, 8'h20, 32'h2222_0000, 1'b0);
    drive_cycle(1'b0, 1'b0);
    clear_fus();
    set_fu(3, 8'h33, 32'h3333_3333, 1'b1);
    set_fu(0, 8'h30, 32'h0000_3030, 1'b0);
    drive_cycle(1'b0, 1'b0);
    clear_fus();
    // pointer is now 1: FU2 must win slot 1 over FU0
    set_fu(0, 8'h40, 32'h0000_4040, 1'b0);
    set_fu(2, 8'h42, 32'h4242_0000, 1'b1);
    drive_cycle(1'b0, 1'b0);
    clear_fus();
  endtask

  task automatic test_flush();
    // pointer is 1 here, so post-flush order FU0 then FU2 shows the pointer cleared
    set_fu(0, 8'h50, 32'h5050_5050, 1'b1);
    set_fu(2, 8'h52, 32'h5252_5252, 1'b0);
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0);
    clear_fus();
    drive_cycle(1'b0, 1'b0);
  endtask

  task automatic test_null_tag();
    do_reset();
    set_fu(1, NUL, 32'h1234_5678, 1'b1);
    set_fu(3, 8'h63, 32'h6363_6363, 1'b1);
    drive_cycle(1'b0, 1'b0);
    clear_fus();
    set_fu(2, 8'h72, 32'h7272_7272, 1'b0);
    set_fu(0, NUL, 32'hFFFF_0000, 1'b1);
    drive_cycle(1'b0, 1'b0);
    clear_fus();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    set_fu(2, 8'h11, 32'hCAFE_0011, 1'b1);
    apply_inputs(1'b0, 1'b0);
    #1;
    checks++;
    if (fu_ready_out !== 4'b0100) begin
      errors++;
      $display("FAIL inflight_grant got=%b exp=0100", fu_ready_out);
    end
    @(posedge clock);
    clear_fus();
    apply_inputs(1'b1, 1'b0);
    #1;
    checks++;
    if (cdb_now() !== null_pair()) begin
      errors++;
      $display("FAIL inflight_cdb got=%h exp=%h", cdb_now(), null_pair());
    end
    @(posedge clock);
    #1;
    checks++;
    if (cdb1_tag_out === 8'h11 || cdb2_tag_out === 8'h11 || cdb_now() !== null_pair()) begin
      errors++;
      $display("FAIL inflight_after got=%h exp=%h", cdb_now(), null_pair());
    end
    model_ptr = 0;
    drive_cycle(1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0);
  endtask

  task automatic test_random();
    int wait_cnt[N];
    logic rst, fl;
    do_reset();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!tb_valid[i] && $urandom_range(0, 1) == 1) begin
          set_fu(i, ($urandom_range(0, 7) == 0) ? NUL : 8'($urandom_range(0, 254)),
                 $urandom, 1'($urandom_range(0, 1)));
          wait_cnt[i] = 0;
        end
      end
      rst = ($urandom_range(0, 59) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      drive_cycle(rst, fl);
      for (int i = 0; i < N; i++) begin
        if (rst || fl) begin
          wait_cnt[i] = 0;
        end else if (last_grant[i]) begin
          checks++;
          if (wait_cnt[i] > 1) begin
            errors++;
            $display("FAIL fairness fu=%0d waited=%0d max=1", i, wait_cnt[i]);
          end
          tb_valid[i] = 1'b0;
        end else if (tb_valid[i]) begin
          wait_cnt[i]++;
        end
      end
    end
    clear_fus();
    drive_cycle(1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clear_fus();
    apply_inputs(1'b1, 1'b0);
    test_reset();
    test_single();
    test_all_valid();
    test_wrap();
    test_flush();
    test_null_tag();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 32: result value width.
REQ-003 Parameter RSTAG_NULL, default 8'hFF: tag driven on an idle CDB.
REQ-004 Reset is named reset and is synchronous, active-high; the clock is named clock.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 flush  input  1  mispredict recovery; drops all grants for the cycle.
REQ-008 fu_valid_in  input  NUM_FU  per-FU result-available request.
REQ-009 fu_tag_in  input  8*NUM_FU  per-FU ROB tag; FU i uses bits [8i+7:8i].
REQ-010 fu_value_in  input  DATA_WIDTH*NUM_FU  per-FU result value; FU i uses slice i.
REQ-011 fu_mispredicted_in  input  NUM_FU  per-FU branch-mispredict flag.
REQ-012 fu_ready_out  output  NUM_FU  per-FU grant (combinational).
REQ-013 cdb1_tag_out / cdb2_tag_out  output  8 each  broadcast tags (registered).
REQ-014 cdb1_value_out / cdb2_value_out  output  DATA_WIDTH each  broadcast values (registered).
REQ-015 cdb1_mispredicted_out / cdb2_mispredicted_out  output  1 each  broadcast mispredict flags (registered).

Function
REQ-016 The block holds a round-robin pointer rr_ptr of width clog2(NUM_FU).
REQ-017 Each cycle, scan FUs circularly from rr_ptr; the first valid FU gets slot 1 and the second valid FU gets slot 2.
REQ-018 fu_ready_out[i] is 1 only when FU i holds slot 1 or slot 2, flush=0 and reset=0; at most two bits are set.
REQ-019 fu_ready_out depends only on fu_valid_in, rr_ptr, flush and reset; no output path to the ROB can stall a grant.
REQ-020 A transfer occurs when fu_valid_in[i] && fu_ready_out[i]; an FU holds valid, tag, value and flag stable until its transfer.
REQ-021 Latency is 1 cycle: slot 1 data appears on cdb1_* and slot 2 data on cdb2_* on the clock edge after the transfer.
REQ-022 An unfilled slot drives tag=RSTAG_NULL, value=0 and mispredicted=0 on its CDB for that cycle.
REQ-023 One grant uses cdb1 only; cdb2 is null.
REQ-024 The same requester is never placed in both slots in one cycle.
REQ-025 If any grant occurs, rr_ptr <= (index of last granted FU + 1) mod NUM_FU; otherwise rr_ptr holds.
REQ-026 Wrap-around: with NUM_FU=4, rr_ptr=3 and FUs 3 and 0 valid, slot1=FU3, slot2=FU0, next rr_ptr=1.
REQ-027 A granted FU presenting tag RSTAG_NULL is consumed, but its slot broadcasts null (value 0, flag 0).
REQ-028 Flush: all fu_ready_out=0 that cycle, both CDBs null next cycle, rr_ptr <= 0.
REQ-029 Flush has priority over every request, including simultaneous valid requests.
REQ-030 Fairness: a continuously valid FU is granted within ceil(NUM_FU/2) cycles when no flush occurs.

Reset
REQ-031 While reset=1: fu_ready_out=0 combinationally, and at the edge rr_ptr <= 0.
REQ-032 While reset=1, both CDB tags are RSTAG_NULL from the edge; values are 0 and flags are 0.
REQ-033 Reset mid-operation discards the in-flight registered broadcast; no broadcast from a pre-reset grant appears after reset.
REQ-034 Reset has priority over flush.

Verification
REQ-035 Reset, then all valid=0 for 3 cycles -> all ready=0; both CDB tags 8'hFF, values 0.
REQ-036 rr_ptr=0; FU1 valid (tag 8'h05, value 32'hDEAD_BEEF, mispredicted 1) -> ready=4'b0010; next cycle cdb1=05/DEADBEEF/1, cdb2 tag FF; rr_ptr=2.
REQ-037 All four FUs valid and held for 4 cycles from rr_ptr=0 -> grant pairs {0,1},{2,3},{0,1},{2,3}; each pair appears on cdb1/cdb2 one cycle later.
REQ-038 rr_ptr=3, FUs 3 and 0 valid -> slot1=FU3 on cdb1, slot2=FU0 on cdb2; rr_ptr=1.
REQ-039 FUs 0 and 2 valid together with flush=1 -> ready=0; next cycle both CDBs null; rr_ptr=0; the held requests are granted the following cycle.
REQ-040 Reset asserted the cycle after a grant of FU2 (tag 8'h11) -> tag 8'h11 never appears on either CDB; outputs are null.
